ao_pair_detect: RTL and testbench
=================================

// Module: ao_pair_detect
// PURPOSE
//  Parametrised, pipelined AND-OR pair detector: NGRP groups of NPAIR input pairs, each group
//  true when any pair has both bits set; flags adjacent groups that are both true.
//  Adds a valid handshake, 2-stage registered pipeline and a HOLD-sample persistence qualifier.
//  Sits between sampled input conditions and the downstream fault/status logic.
// PARAMETERS
//  NGRP  = 3  number of groups (>=2)
//  NPAIR = 2  AND pairs per group (>=1)
//  HOLD  = 4  consecutive valid hit samples needed to assert y_qual (>=1)
//  CW    = $clog2(HOLD+1)  derived, hit_cnt width (localparam)
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               asynchronous, active-high reset
//  in_valid  in   1               in_data is a valid sample this cycle
//  in_data   in   NGRP*NPAIR*2    group k, pair p: bits [(k*NPAIR+p)*2 +: 2]
//  clr       in   1               sticky clear (present only with AO_STICKY_EN)
//  out_valid out  1               pulses 1 cycle when stage-2 results update
//  pair_hit  out  NGRP-1          bit k = group k AND group k+1
//  y         out  1               OR of pair_hit
//  y_qual    out  1               y persisted HOLD consecutive valid samples
//  hit_cnt   out  CW              consecutive-hit count, saturating at HOLD
// BEHAVIOUR
//  - Reset (async, rst=1): all pipeline regs, out_valid, pair_hit, y, y_qual, hit_cnt = 0.
//  - Group term: g[k] = |{a&b for each pair p of group k} (a = even bit, b = odd bit).
//  - Stage 1: if in_valid, g_q <= g, v1 <= 1; else v1 <= 0, g_q holds.
//  - Stage 2: if v1, pair_hit <= g_q[k]&g_q[k+1] for all k, y <= |pair_hit_next; out_valid <= v1.
//  - Latency: in_valid at edge N -> out_valid=1 with results after edge N+2. Throughput 1/cycle.
//  - Bubbles (in_valid=0): outputs hold last value, out_valid=0, hit_cnt unchanged.
//  - Counter (updates only when v1): hit_cnt <= y_next ? min(hit_cnt+1, HOLD) : 0.
//  - y_qual <= (hit_cnt_next == HOLD), registered with stage 2; drops the sample y_next=0.
//  - Saturation: hit_cnt never exceeds HOLD; no wrap. HOLD=1 -> y_qual tracks y.
//  - Reset mid-operation: in-flight samples discarded; counting restarts from 0.
//  - No backpressure: consumer must accept every out_valid pulse.
// CONFIGURATION
//  AO_STICKY_EN defined: clr port present; y_qual latches 1 once qualified and stays 1
//    until clr=1; clr (sampled on clk) zeroes y_qual and hit_cnt; clr wins over a
//    qualifying sample in the same cycle. pair_hit/y unaffected by clr.
//  AO_STICKY_EN undefined: clr port absent; y_qual is non-sticky as described above.
// TESTING (NGRP=3, NPAIR=2, HOLD=4)
//  1. rst=1 mid-stream then release -> all outputs 0; first out_valid 2 cycles after in_valid.
//  2. in_data=12'h033 -> pair_hit=2'b01, y=1; 12'h330 -> 2'b10, y=1; 12'h303 -> 2'b00, y=0.
//  3. in_data=12'h555 (no pair complete) -> pair_hit=0, y=0; 12'hCCC -> pair_hit=2'b11, y=1.
//  4. 12'h033 x4 valid with bubbles between -> hit_cnt 1,2,3,4, y_qual=1 on 4th only; one
//     12'h000 sample -> hit_cnt=0, y_qual=0 (non-sticky build).
//  5. 12'h033 x6 back-to-back -> hit_cnt saturates at 4, y_qual stays 1, out_valid every cycle.
//  6. AO_STICKY_EN: qualify, then 12'h000 -> y_qual stays 1; clr=1 on qualifying cycle -> y_qual=0.

Source files
------------

// File: rtl/ao_pair_detect.sv
// ao_pair_detect: two-stage pipelined AND-OR pair detector with a hit-persistence qualifier.
// Define AO_STICKY_EN to add the clr port and make y_qual latch until cleared.
module ao_pair_detect #(
    parameter int NGRP  = 3,
    parameter int NPAIR = 2,
    parameter int HOLD  = 4,
    localparam int CW   = $clog2(HOLD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NGRP*NPAIR*2-1:0]   in_data,
`ifdef AO_STICKY_EN
    input  logic                      clr,
`endif
    output logic                      out_valid,
    output logic [NGRP-2:0]           pair_hit,
    output logic                      y,
    output logic                      y_qual,
    output logic [CW-1:0]             hit_cnt
);

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    logic [NGRP-1:0] grp;
    logic [NGRP-1:0] g_q, g_d;
    logic            v1_q, v1_d;
    logic            out_valid_q, out_valid_d;
    logic [NGRP-2:0] pair_hit_q, pair_hit_d;
    logic            y_q, y_d;
    logic            y_qual_q, y_qual_d;
    logic [CW-1:0]   hit_cnt_q, hit_cnt_d;

    logic [NGRP-2:0] pair_hit_next;
    logic            y_next;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   cnt_next;

    // Each pair is (even bit, odd bit); a group fires when any of its pairs is fully set.
    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            logic acc;
            acc = 1'b0;
            for (int p = 0; p < NPAIR; p++) begin
                acc = acc | (in_data[(k*NPAIR+p)*2] & in_data[(k*NPAIR+p)*2+1]);
            end
            grp[k] = acc;
        end
    end

    always_comb begin
        g_d  = g_q;
        v1_d = in_valid;
        if (in_valid) begin
            g_d = grp;
        end

        pair_hit_next = g_q[NGRP-2:0] & g_q[NGRP-1:1];
        y_next        = |pair_hit_next;
        cnt_inc       = (hit_cnt_q == HOLD_C) ? HOLD_C : hit_cnt_q + 1'b1;
        cnt_next      = y_next ? cnt_inc : '0;

        out_valid_d = v1_q;
        pair_hit_d  = pair_hit_q;
        y_d         = y_q;
        hit_cnt_d   = hit_cnt_q;
        y_qual_d    = y_qual_q;
        // Stage 2 only moves on valid samples, so bubbles leave the results frozen.
        if (v1_q) begin
            pair_hit_d = pair_hit_next;
            y_d        = y_next;
            hit_cnt_d  = cnt_next;
`ifdef AO_STICKY_EN
            y_qual_d   = y_qual_q | (cnt_next == HOLD_C);
`else
            y_qual_d   = (cnt_next == HOLD_C);
`endif
        end
`ifdef AO_STICKY_EN
        if (clr) begin
            y_qual_d  = 1'b0;
            hit_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q         <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            pair_hit_q  <= '0;
            y_q         <= 1'b0;
            y_qual_q    <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            g_q         <= g_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            pair_hit_q  <= pair_hit_d;
            y_q         <= y_d;
            y_qual_q    <= y_qual_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pair_hit  = pair_hit_q;
    assign y         = y_q;
    assign y_qual    = y_qual_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_ao_pair_detect.sv
// Scoreboard bench for ao_pair_detect (NGRP=3, NPAIR=2, HOLD=4); hand-computed expectations
// are queued at issue time and popped by a monitor on every out_valid pulse.
module tb_ao_pair_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic [1:0]  pair_hit;
    logic        y;
    logic        y_qual;
    logic [2:0]  hit_cnt;

`ifdef AO_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [1:0] ph;
        logic       y;
        logic [2:0] cnt;
        logic       q;
        int         issue;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '{ph: 2'b00, y: 1'b0, cnt: 3'd0, q: 1'b0, issue: 0};
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ao_pair_detect #(.NGRP(3), .NPAIR(2), .HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef AO_STICKY_EN
        .clr       (clr),
`endif
        .out_valid (out_valid),
        .pair_hit  (pair_hit),
        .y         (y),
        .y_qual    (y_qual),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one valid sample right after a rising edge, queue its expectation, then idle for gap cycles.
    task automatic apply_stimulus(input logic [11:0] d, input logic [1:0] ph, input logic yy,
                                  input logic [2:0] cnt, input logic q, input int gap);
        exp_t e;
        e.ph = ph; e.y = yy; e.cnt = cnt; e.q = q; e.issue = cyc;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops on out_valid, otherwise checks that results hold (or are zero in reset).
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_exp = '{ph: 2'b00, y: 1'b0, cnt: 3'd0, q: 1'b0, issue: 0};
            check_output("rst_out_valid", int'(out_valid), 0);
            check_output("rst_pair_hit", int'(pair_hit), 0);
            check_output("rst_y", int'(y), 0);
            check_output("rst_y_qual", int'(y_qual), 0);
            check_output("rst_hit_cnt", int'(hit_cnt), 0);
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_output("pair_hit", int'(pair_hit), int'(e.ph));
                check_output("y", int'(y), int'(e.y));
                check_output("hit_cnt", int'(hit_cnt), int'(e.cnt));
                check_output("y_qual", int'(y_qual), int'(e.q));
                check_output("latency", cyc - e.issue, 2);
                last_exp = e;
            end
        end else begin
            check_output("hold_pair_hit", int'(pair_hit), int'(last_exp.ph));
            check_output("hold_y", int'(y), int'(last_exp.y));
            check_output("hold_hit_cnt", int'(hit_cnt), int'(last_exp.cnt));
            check_output("hold_y_qual", int'(y_qual), int'(last_exp.q));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, 1'b0, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd2, 1'b0, 3);

        // A sample in flight when reset hits must vanish, and counting restarts from zero.
        in_valid = 1'b1;
        in_data  = 12'hCCC;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, 1'b0, 0);
        apply_stimulus(12'h330, 2'b10, 1'b1, 3'd2, 1'b0, 0);
        apply_stimulus(12'h303, 2'b00, 1'b0, 3'd0, 1'b0, 1);
        apply_stimulus(12'h555, 2'b00, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus(12'hCCC, 2'b11, 1'b1, 3'd1, 1'b0, 0);
        apply_stimulus(12'h000, 2'b00, 1'b0, 3'd0, 1'b0, 0);

        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, 1'b0, 2);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd2, 1'b0, 2);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd3, 1'b0, 2);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd4, 1'b1, 2);
        apply_stimulus(12'h000, 2'b00, 1'b0, 3'd0, STICKY, 0);

        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, STICKY, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd2, STICKY, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd3, STICKY, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd4, 1'b1, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd4, 1'b1, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd4, 1'b1, 0);
        apply_stimulus(12'h000, 2'b00, 1'b0, 3'd0, STICKY, 3);

`ifdef AO_STICKY_EN
        // Idle clear drops the latched qualifier without touching pair_hit/y.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        last_exp.q   = 1'b0;
        last_exp.cnt = 3'd0;
        @(posedge clk); #1;

        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, 1'b0, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd2, 1'b0, 0);
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd3, 1'b0, 0);
        // clr lands on the edge where the 4th sample would qualify; clear wins.
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd0, 1'b0, 0);
        clr = 1'b1;
        apply_stimulus(12'h033, 2'b01, 1'b1, 3'd1, 1'b0, 0);
        clr = 1'b0;
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_output("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
